// File: rtl/mda_imu_uart_rx.sv
// IMU reply UART receiver: 16x-oversampled 8N1 (8E1 with IMU_RX_PARITY_EN) decoder feeding a byte FIFO.
// Latency: rx_valid rises 1 cycle after the stop-bit decision tick (mid stop bit, tick 9).
// Backpressure: rx_ready stalls the FIFO head; a byte arriving while full is dropped with an overrun pulse.
//
// Optional feature macro: IMU_RX_PARITY_EN (even parity bit between data and stop).
// Ports:
//   clk, reset_n        system clock (CLOCK_50) and async active-low reset
//   enable              0 holds the decoder idle and flushes the FIFO
//   rxd                 asynchronous serial line, idle high
//   rx_data/rx_valid/rx_ready   first-word-fall-through byte stream
//   fifo_level          bytes currently stored
//   overrun, frame_err, parity_err   single-cycle event pulses

module mda_imu_uart_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  output logic                     rd_vld,
  output logic [W-1:0]             rd_dat,
  input  logic                     rd_rdy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);
  // Generic FWFT FIFO with synchronous flush.
  // Latency: a write is visible on rd_* the cycle after it is accepted.
  // Backpressure: writes while full are rejected (ovf) unless a read frees the slot in the same cycle.

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, rd_fire, wr_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_vld  = (count != '0);
  assign rd_fire = rd_vld & rd_rdy;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en   = wr_vld & (~full | rd_fire);
  assign ovf     = wr_vld & full & ~rd_fire;
  assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;
  assign level   = count;

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_fire)      count <= count + 1'b1;
      else if (!wr_en && rd_fire) count <= count - 1'b1;
    end
  end
endmodule

module mda_imu_uart_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          parity_err
);

  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef IMU_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t           state, nxt;
  logic             rxd_s1, rxd_s2;
  logic             en_q;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       samp_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             s7, s8;
  logic             active, tick, maj;
  logic             push, fe_nxt;
  logic             fifo_ovf;
  logic             flush;
`ifdef IMU_RX_PARITY_EN
  logic             par_bad;
  logic             pe_nxt;
`endif

  // Divider and sample counter only run inside a frame, so they restart at every start edge.
  assign active = (state != IDLE) && (state != BREAK);
  assign tick   = active && (div_cnt == DIV_W'(DIV - 1));
  // Majority vote of samples 7, 8 and the live sample at tick 9.
  assign maj    = (s7 & s8) | (s7 & rxd_s2) | (s8 & rxd_s2);
  assign flush  = ~enable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt    = state;
    push   = 1'b0;
    fe_nxt = 1'b0;
`ifdef IMU_RX_PARITY_EN
    pe_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        // First enabled cycle with the line already low: wait for it to go high instead of starting.
        if (!rxd_s2 && !en_q) nxt = BREAK;
        else if (!rxd_s2)     nxt = START;
      end
      START: begin
        if (tick && samp_cnt == 4'd9 && maj) nxt = IDLE;
        else if (tick && samp_cnt == 4'd15)  nxt = DATA;
      end
      DATA: begin
        if (tick && samp_cnt == 4'd15 && bit_cnt == 3'd7) begin
`ifdef IMU_RX_PARITY_EN
          nxt = PARITY;
`else
          nxt = STOP;
`endif
        end
      end
`ifdef IMU_RX_PARITY_EN
      PARITY: begin
        if (tick && samp_cnt == 4'd9)  pe_nxt = ^shreg ^ maj;
        if (tick && samp_cnt == 4'd15) nxt = STOP;
      end
`endif
      STOP: begin
        // Decide at mid stop bit and return early so the next start edge is caught promptly.
        if (tick && samp_cnt == 4'd9) begin
          if (maj) begin
`ifdef IMU_RX_PARITY_EN
            push = ~par_bad;
`else
            push = 1'b1;
`endif
            nxt = IDLE;
          end else begin
            fe_nxt = 1'b1;
            nxt    = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxd_s2) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (!enable) begin
      nxt    = IDLE;
      push   = 1'b0;
      fe_nxt = 1'b0;
`ifdef IMU_RX_PARITY_EN
      pe_nxt = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_s1    <= 1'b1;
      rxd_s2    <= 1'b1;
      en_q      <= 1'b0;
      div_cnt   <= '0;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      s7        <= 1'b1;
      s8        <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rxd_s1    <= rxd;
      rxd_s2    <= rxd_s1;
      en_q      <= enable;
      frame_err <= fe_nxt;
      overrun   <= fifo_ovf;

      if (!active || tick) div_cnt <= '0;
      else                 div_cnt <= div_cnt + 1'b1;

      if (!active)  samp_cnt <= '0;
      else if (tick) samp_cnt <= samp_cnt + 1'b1;

      if (tick && samp_cnt == 4'd7) s7 <= rxd_s2;
      if (tick && samp_cnt == 4'd8) s8 <= rxd_s2;

      if (state == START) bit_cnt <= '0;
      else if (state == DATA && tick && samp_cnt == 4'd15) bit_cnt <= bit_cnt + 1'b1;

      // LSB arrives first, so shift in from the top.
      if (state == DATA && tick && samp_cnt == 4'd9) shreg <= {maj, shreg[7:1]};
    end
  end

`ifdef IMU_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= pe_nxt;
      if (state == START)  par_bad <= 1'b0;
      else if (pe_nxt)     par_bad <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  mda_imu_uart_rx_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .wr_vld  (push),
    .wr_dat  (shreg),
    .rd_vld  (rx_valid),
    .rd_dat  (rx_data),
    .rd_rdy  (rx_ready),
    .level   (fifo_level),
    .ovf     (fifo_ovf)
  );

endmodule

// File: tb/tb_mda_imu_uart_rx.sv
// Bench for mda_imu_uart_rx: directed frames driven on rxd, expected bytes queued at send time,
// a negedge monitor pops and compares every accepted byte and counts error pulses.
// 12 MHz clock at 115200 baud gives DIV = trunc(6.51) = 6, i.e. 96 clocks per bit.

module tb_mda_imu_uart_rx;

  localparam int BIT_CLKS = 96;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] fifo_level;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  int pop_cnt = 0;
  int push_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
`ifdef IMU_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  always #10 clk = ~clk;

  mda_imu_uart_rx #(
    .CLK_HZ     (12000000),
    .BAUD       (115200),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_level (fifo_level),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic expect_push);
    if (expect_push) begin
      exp_q.push_back(b);
      push_cnt++;
    end
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clks(BIT_CLKS);
    end
`ifdef IMU_RX_PARITY_EN
    rxd = (^b) ^ par_flip;
    wait_clks(BIT_CLKS);
`endif
    rxd = stop_bit;
    wait_clks(BIT_CLKS);
    rxd = 1'b1;
  endtask

  // Monitor: compares each accepted byte with the scoreboard and counts event pulses.
  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_err)  fe_cnt++;
      if (overrun)    ov_cnt++;
      if (parity_err) pe_cnt++;
      if (rx_valid && rx_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h, no byte expected", rx_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("rx_data", int'(rx_data), int'(exp_b));
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    wait_clks(5);
    check("reset_rx_valid",   int'(rx_valid),   0);
    check("reset_fifo_level", int'(fifo_level), 0);
    check("reset_rx_data",    int'(rx_data),    0);
    check("reset_overrun",    int'(overrun),    0);
    check("reset_frame_err",  int'(frame_err),  0);
    check("reset_parity_err", int'(parity_err), 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    wait_clks(10);

    // Single byte, consumer always ready.
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_clks(50);
    check("a5_delivered", exp_q.size(), 0);
    check("a5_frame_err", fe_cnt, 0);
    check("a5_overrun",   ov_cnt, 0);
    check("a5_parity",    pe_cnt, 0);

    // Short low glitch on an idle line.
    rxd = 1'b0;
    wait_clks(3);
    rxd = 1'b1;
    wait_clks(200);
    check("glitch_level",     int'(fifo_level), 0);
    check("glitch_frame_err", fe_cnt, 0);
    check("glitch_pops",      pop_cnt, 1);

    // Bad stop bit, then a good byte.
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_clks(50);
    check("stop0_frame_err", fe_cnt, 1);
    check("stop0_level",     int'(fifo_level), 0);
    send_frame(8'h55, 1'b1, 1'b1);
    wait_clks(50);
    check("after_err_55", exp_q.size(), 0);

    // Seventeen bytes into a stalled 16-entry FIFO.
    rx_ready = 1'b0;
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, i < 16);
    wait_clks(50);
    check("full_level",   int'(fifo_level), 16);
    check("full_overrun", ov_cnt, 1);
    check("full_valid",   int'(rx_valid), 1);
    rx_ready = 1'b1;
    wait_clks(40);
    check("drain_done",  exp_q.size(), 0);
    check("drain_level", int'(fifo_level), 0);

    // Drop enable mid-byte with bytes queued.
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(8'hF0 + 8'(i), 1'b1, 1'b0);
    wait_clks(50);
    check("queued_level", int'(fifo_level), 4);
    rxd = 1'b0;
    wait_clks(BIT_CLKS * 3);
    enable = 1'b0;
    wait_clks(2);
    check("disable_level", int'(fifo_level), 0);
    check("disable_valid", int'(rx_valid), 0);
    rxd = 1'b1;
    wait_clks(20);
    enable   = 1'b1;
    rx_ready = 1'b1;
    wait_clks(20);
    send_frame(8'h81, 1'b1, 1'b1);
    wait_clks(50);
    check("reenable_81",   exp_q.size(), 0);
    check("disable_no_fe", fe_cnt, 1);

    // Re-enable while the line is held low: no false start.
    enable = 1'b0;
    rxd    = 1'b0;
    wait_clks(10);
    enable = 1'b1;
    wait_clks(1500);
    check("lowline_no_fe",  fe_cnt, 1);
    check("lowline_level",  int'(fifo_level), 0);
    rxd = 1'b1;
    wait_clks(50);
    send_frame(8'h6E, 1'b1, 1'b1);
    wait_clks(50);
    check("lowline_6e", exp_q.size(), 0);

`ifdef IMU_RX_PARITY_EN
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    wait_clks(50);
    check("par_bad_pulse", pe_cnt, 1);
    check("par_bad_level", int'(fifo_level), 0);
    check("par_bad_no_fe", fe_cnt, 1);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clks(50);
    check("par_ok_07",    exp_q.size(), 0);
    check("par_ok_pulse", pe_cnt, 1);
`else
    check("no_parity_pulses", pe_cnt, 0);
`endif

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_pop_count",   pop_cnt, push_cnt);
    check("final_overruns",    ov_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
